// File: rtl/pipeline_ctrl_if.sv
// Stall request / stall vector bundle between the pipeline stages and pipeline_ctrl.
// master: stage side (raises requests, consumes stall); slave: the controller.
interface pipeline_ctrl_if;
    logic       stallreq_from_if;
    logic       stallreq_from_id;
    logic       stallreq_from_ex;
    logic [5:0] stall;

    modport master (
        output stallreq_from_if,
        output stallreq_from_id,
        output stallreq_from_ex,
        input  stall
    );

    modport slave (
        input  stallreq_from_if,
        input  stallreq_from_id,
        input  stallreq_from_ex,
        output stall
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall controller: combinational stall vector plus registered source/episode/watchdog tracking.
// Define CTRL_PERF_EN to build the saturating performance counters; otherwise their ports read 0.
module pipeline_ctrl #(
    parameter int unsigned WDOG_LIMIT = 255,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    stall_bus,
    output logic [1:0]        ctrl_state,
    output logic [15:0]       episode_len,
    output logic              stall_timeout,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_ex_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_IF  = 2'd1,
        ST_ID  = 2'd2,
        ST_EX  = 2'd3
    } state_e;

    localparam logic [15:0] WDOG_16 = 16'(WDOG_LIMIT);
    localparam logic [15:0] EP_MAX  = 16'hFFFF;

    logic [5:0]  stall_s;
    logic        stall_any_s;
    state_e      src_s;
    state_e      state_q;
    logic [15:0] episode_d;
    logic [15:0] episode_q;
    logic        timeout_d;
    logic        timeout_q;

    // Priority decode: highest requesting stage wins; flat so requests reach stall in two gate levels.
    always_comb begin
        stall_s = 6'b000000;
        src_s   = ST_RUN;
        if (rst) begin
            stall_s = 6'b000000;
            src_s   = ST_RUN;
        end else if (stall_bus.stallreq_from_ex) begin
            stall_s = 6'b001111;
            src_s   = ST_EX;
        end else if (stall_bus.stallreq_from_id) begin
            stall_s = 6'b000111;
            src_s   = ST_ID;
        end else if (stall_bus.stallreq_from_if) begin
            stall_s = 6'b000011;
            src_s   = ST_IF;
        end else begin
            stall_s = 6'b000000;
            src_s   = ST_RUN;
        end
    end

    assign stall_any_s     = |stall_s;
    assign stall_bus.stall = stall_s;

    // Episode length and sticky watchdog; a source change without a free cycle keeps counting.
    always_comb begin
        episode_d = 16'd0;
        timeout_d = timeout_q;
        if (stall_any_s) begin
            if (episode_q == EP_MAX) begin
                episode_d = episode_q;
            end else begin
                episode_d = episode_q + 16'd1;
            end
        end else begin
            episode_d = 16'd0;
        end
        if (stall_any_s && (episode_d == WDOG_16)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Stall-source FSM and episode tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            episode_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= src_s;
            episode_q <= episode_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctrl_state    = state_q;
    assign episode_len   = episode_q;
    assign stall_timeout = timeout_q;

`ifdef CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] perf_all_d;
    logic [PERF_W-1:0] perf_all_q;
    logic [PERF_W-1:0] perf_ex_d;
    logic [PERF_W-1:0] perf_ex_q;

    // Saturating increments; counters only clear on rst.
    always_comb begin
        perf_all_d = perf_all_q;
        perf_ex_d  = perf_ex_q;
        if (stall_any_s && (perf_all_q != PERF_MAX)) begin
            perf_all_d = perf_all_q + PERF_ONE;
        end else begin
            perf_all_d = perf_all_q;
        end
        if (stall_bus.stallreq_from_ex && (perf_ex_q != PERF_MAX)) begin
            perf_ex_d = perf_ex_q + PERF_ONE;
        end else begin
            perf_ex_d = perf_ex_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_all_q <= {PERF_W{1'b0}};
            perf_ex_q  <= {PERF_W{1'b0}};
        end else begin
            perf_all_q <= perf_all_d;
            perf_ex_q  <= perf_ex_d;
        end
    end

    assign perf_stall_cycles    = perf_all_q;
    assign perf_ex_stall_cycles = perf_ex_q;
`else
    assign perf_stall_cycles    = {PERF_W{1'b0}};
    assign perf_ex_stall_cycles = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (WDOG_LIMIT=4, PERF_W=4); honours CTRL_PERF_EN.
module tb_pipeline_ctrl;
    logic       clk;
    logic       rst;
    logic [1:0] ctrl_state;
    logic [15:0] episode_len;
    logic       stall_timeout;
    logic [3:0] perf_stall_cycles;
    logic [3:0] perf_ex_stall_cycles;
    int         checks;
    int         failures;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.WDOG_LIMIT(4), .PERF_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_bus            (bus),
        .ctrl_state           (ctrl_state),
        .episode_len          (episode_len),
        .stall_timeout        (stall_timeout),
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_ex_stall_cycles (perf_ex_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r_if, input logic r_id, input logic r_ex);
        bus.stallreq_from_if = r_if;
        bus.stallreq_from_id = r_id;
        bus.stallreq_from_ex = r_ex;
        #1;
    endtask

    task automatic do_reset;
        set_req(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_req(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.stall !== 6'b000000) begin
            failures++; $display("FAIL reset_stall: got %b expected %b", bus.stall, 6'b000000);
        end
        step();
        checks++;
        if (ctrl_state !== 2'd0 || episode_len !== 16'd0 || stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got state=%0d ep=%0d to=%0d expected 0 0 0", ctrl_state, episode_len, stall_timeout);
        end
        checks++;
        if (perf_stall_cycles !== 4'd0 || perf_ex_stall_cycles !== 4'd0) begin
            failures++;
            $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_stall_cycles, perf_ex_stall_cycles);
        end
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.stall !== 6'b000000 || ctrl_state !== 2'd0) begin
            failures++; $display("FAIL post_reset_idle: got stall=%b state=%0d expected 000000 0", bus.stall, ctrl_state);
        end
    endtask

    task automatic test_priority;
        do_reset();
        set_req(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.stall !== 6'b001111) begin
            failures++; $display("FAIL prio_all_stall: got %b expected %b", bus.stall, 6'b001111);
        end
        step();
        checks++;
        if (ctrl_state !== 2'd3 || episode_len !== 16'd1) begin
            failures++; $display("FAIL prio_all_state: got state=%0d ep=%0d expected 3 1", ctrl_state, episode_len);
        end
        set_req(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.stall !== 6'b000111) begin
            failures++; $display("FAIL prio_id_stall: got %b expected %b", bus.stall, 6'b000111);
        end
        step();
        checks++;
        if (ctrl_state !== 2'd2 || episode_len !== 16'd2) begin
            failures++; $display("FAIL prio_id_state: got state=%0d ep=%0d expected 2 2", ctrl_state, episode_len);
        end
        set_req(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.stall !== 6'b000011) begin
            failures++; $display("FAIL prio_if_stall: got %b expected %b", bus.stall, 6'b000011);
        end
        step();
        checks++;
        if (ctrl_state !== 2'd1 || episode_len !== 16'd3) begin
            failures++; $display("FAIL prio_if_state: got state=%0d ep=%0d expected 1 3", ctrl_state, episode_len);
        end
        set_req(1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.stall !== 6'b000000 || ctrl_state !== 2'd0 || episode_len !== 16'd0) begin
            failures++;
            $display("FAIL prio_release: got stall=%b state=%0d ep=%0d expected 000000 0 0", bus.stall, ctrl_state, episode_len);
        end
    endtask

    task automatic test_madd;
        logic [3:0] exp_ex;
        do_reset();
        set_req(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (bus.stall !== 6'b001111) begin
                failures++; $display("FAIL madd_stall_%0d: got %b expected %b", i, bus.stall, 6'b001111);
            end
            step();
            checks++;
            if (episode_len !== 16'(i)) begin
                failures++; $display("FAIL madd_ep_%0d: got %0d expected %0d", i, episode_len, i);
            end
        end
        set_req(1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (episode_len !== 16'd0 || ctrl_state !== 2'd0) begin
            failures++; $display("FAIL madd_free: got ep=%0d state=%0d expected 0 0", episode_len, ctrl_state);
        end
`ifdef CTRL_PERF_EN
        exp_ex = 4'd2;
`else
        exp_ex = 4'd0;
`endif
        checks++;
        if (perf_ex_stall_cycles !== exp_ex) begin
            failures++; $display("FAIL madd_perf_ex: got %0d expected %0d", perf_ex_stall_cycles, exp_ex);
        end
    endtask

    task automatic test_watchdog;
        logic exp_to;
        do_reset();
        set_req(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_to = (i >= 4) ? 1'b1 : 1'b0;
            checks++;
            if (stall_timeout !== exp_to || episode_len !== 16'(i) || ctrl_state !== 2'd2) begin
                failures++;
                $display("FAIL wdog_cycle_%0d: got to=%0d ep=%0d state=%0d expected %0d %0d 2",
                         i, stall_timeout, episode_len, ctrl_state, exp_to, i);
            end
        end
        set_req(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.stall !== 6'b000000) begin
            failures++; $display("FAIL wdog_no_effect: got %b expected %b", bus.stall, 6'b000000);
        end
        step();
        step();
        checks++;
        if (stall_timeout !== 1'b1 || episode_len !== 16'd0) begin
            failures++; $display("FAIL wdog_sticky: got to=%0d ep=%0d expected 1 0", stall_timeout, episode_len);
        end
        do_reset();
        checks++;
        if (stall_timeout !== 1'b0) begin
            failures++; $display("FAIL wdog_clear: got %0d expected 0", stall_timeout);
        end
    endtask

    task automatic test_saturation;
        logic [3:0] exp_perf;
        do_reset();
        set_req(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
`ifdef CTRL_PERF_EN
            exp_perf = (i > 15) ? 4'd15 : 4'(i);
`else
            exp_perf = 4'd0;
`endif
            checks++;
            if (perf_stall_cycles !== exp_perf || perf_ex_stall_cycles !== 4'd0 || episode_len !== 16'(i)) begin
                failures++;
                $display("FAIL sat_cycle_%0d: got perf=%0d ex=%0d ep=%0d expected %0d 0 %0d",
                         i, perf_stall_cycles, perf_ex_stall_cycles, episode_len, exp_perf, i);
            end
        end
        set_req(1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (perf_stall_cycles !== exp_perf) begin
            failures++; $display("FAIL sat_hold: got %0d expected %0d", perf_stall_cycles, exp_perf);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_req(1'b0, 1'b0, 1'b1);
        step();
        step();
        checks++;
        if (episode_len !== 16'd2 || ctrl_state !== 2'd3) begin
            failures++; $display("FAIL mid_before: got ep=%0d state=%0d expected 2 3", episode_len, ctrl_state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 6'b000000) begin
            failures++; $display("FAIL mid_stall: got %b expected %b", bus.stall, 6'b000000);
        end
        step();
        checks++;
        if (episode_len !== 16'd0 || ctrl_state !== 2'd0 || perf_ex_stall_cycles !== 4'd0) begin
            failures++;
            $display("FAIL mid_after: got ep=%0d state=%0d ex=%0d expected 0 0 0", episode_len, ctrl_state, perf_ex_stall_cycles);
        end
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.stallreq_from_if = 1'b0;
        bus.stallreq_from_id = 1'b0;
        bus.stallreq_from_ex = 1'b0;
        test_reset();
        test_priority();
        test_madd();
        test_watchdog();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
